// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin owner selection for the single MAC transmit path.
// A winner is latched in IDLE, given one settle cycle through the buffer mux,
// then launched with a doorbell pulse. The transfer is tracked through
// tx_available (fall = started, rise = finished), with timeouts on both phases.
// The owner gets a one-cycle done pulse, with err set if the transfer timed out.
module tx_arbiter #(
  parameter int N_REQ     = 2,
  parameter int IDX_W     = $clog2(N_REQ),
  parameter int LAUNCH_TO = 64,
  parameter int SEND_TO   = 8191
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_REQ-1:0] req,
  input  logic             tx_available,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] sel,
  output logic             tx_doorbell,
  output logic [N_REQ-1:0] done,
  output logic             err,
  output logic             busy
);

  // Wide enough to reach SEND_TO-1, so the timer never has to saturate.
  localparam int TMR_W = $clog2(SEND_TO + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LAUNCH,
    ST_SEND,
    ST_DONE
  } state_t;

  state_t           state_reg,    state_next;
  logic [N_REQ-1:0] grant_reg,    grant_next;
  logic [IDX_W-1:0] sel_reg,      sel_next;
  logic [IDX_W-1:0] last_reg,     last_next;
  logic [TMR_W-1:0] timer_reg,    timer_next;
  logic             doorbell_reg, doorbell_next;
  logic [N_REQ-1:0] done_reg,     done_next;
  logic             err_reg,      err_next;
  logic             busy_reg,     busy_next;

  // Round-robin search order: cand_idx[0] is last+1, cand_idx[1] is last+2, ...
  // The sum never exceeds 2*N_REQ-1, so one subtraction is enough for the wrap.
  logic [IDX_W-1:0] cand_idx [N_REQ];
  logic             rr_found;
  logic [IDX_W-1:0] rr_idx;
  logic [N_REQ-1:0] rr_onehot;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_cand
      localparam int OFF = gi + 1;
      assign cand_idx[gi] = (int'(last_reg) + OFF >= N_REQ)
                          ? IDX_W'(int'(last_reg) + OFF - N_REQ)
                          : IDX_W'(int'(last_reg) + OFF);
    end
  endgenerate

  // Pick the first active requester in search order. The scan runs backwards
  // so the earliest candidate, the one nearest last+1, is written last and wins.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[cand_idx[k]]) begin
        rr_found = 1'b1;
        rr_idx   = cand_idx[k];
      end
    end
  end

  assign rr_onehot = N_REQ'(1) << rr_idx;

  // Next-state and next-output logic. The pulses (doorbell, done, err) default to 0.
  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    sel_next      = sel_reg;
    last_next     = last_reg;
    timer_next    = timer_reg;
    doorbell_next = 1'b0;
    done_next     = '0;
    err_next      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (rr_found) begin
          grant_next = rr_onehot;
          sel_next   = rr_idx;
          state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (!req[sel_reg]) begin
          // The producer withdrew before launch, so release the buffer quietly.
          grant_next = '0;
          state_next = ST_IDLE;
        end else if (tx_available) begin
          doorbell_next = 1'b1;
          timer_next    = '0;
          state_next    = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        if (!tx_available) begin
          timer_next = '0;
          state_next = ST_SEND;
        end else if (timer_reg == TMR_W'(LAUNCH_TO - 1)) begin
          err_next   = 1'b1;
          done_next  = grant_reg;
          state_next = ST_DONE;
        end else begin
          timer_next = timer_reg + TMR_W'(1);
        end
      end
      ST_SEND: begin
        if (tx_available) begin
          done_next  = grant_reg;
          state_next = ST_DONE;
        end else if (timer_reg == TMR_W'(SEND_TO - 1)) begin
          err_next   = 1'b1;
          done_next  = grant_reg;
          state_next = ST_DONE;
        end else begin
          timer_next = timer_reg + TMR_W'(1);
        end
      end
      ST_DONE: begin
        last_next  = sel_reg;
        grant_next = '0;
        timer_next = '0;
        state_next = ST_IDLE;
      end
      default: begin
        grant_next = '0;
        state_next = ST_IDLE;
      end
    endcase

    busy_next = (state_next != ST_IDLE);
  end

  // State and registered outputs. The reset is synchronous and active low.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg    <= ST_IDLE;
      grant_reg    <= '0;
      sel_reg      <= '0;
      last_reg     <= IDX_W'(N_REQ - 1);
      timer_reg    <= '0;
      doorbell_reg <= 1'b0;
      done_reg     <= '0;
      err_reg      <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      sel_reg      <= sel_next;
      last_reg     <= last_next;
      timer_reg    <= timer_next;
      doorbell_reg <= doorbell_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
      busy_reg     <= busy_next;
    end
  end

  assign grant       = grant_reg;
  assign sel         = sel_reg;
  assign tx_doorbell = doorbell_reg;
  assign done        = done_reg;
  assign err         = err_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: transaction-level bench for tx_arbiter.
// For each transfer, the model predicts the round-robin winner and the
// done/err outcome. It works this out from the tx_available profile with
// plain cycle arithmetic.
module tb_tx_arbiter;

  localparam int N_REQ     = 2;
  localparam int IDX_W     = 1;
  localparam int LAUNCH_TO = 16;
  localparam int SEND_TO   = 40;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [N_REQ-1:0] req = '0;
  logic             tx_available = 1'b1;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] sel;
  logic             tx_doorbell;
  logic [N_REQ-1:0] done;
  logic             err;
  logic             busy;

  int checks   = 0;
  int failures = 0;
  int last_m   = N_REQ - 1;

  tx_arbiter #(
    .N_REQ(N_REQ), .IDX_W(IDX_W), .LAUNCH_TO(LAUNCH_TO), .SEND_TO(SEND_TO)
  ) dut (
    .clk(clk), .rstn(rstn), .req(req), .tx_available(tx_available),
    .grant(grant), .sel(sel), .tx_doorbell(tx_doorbell),
    .done(done), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Round-robin reference: first set bit at last+1, last+2, ... modulo N_REQ.
  function automatic int rr_pick(input logic [N_REQ-1:0] r, input int last);
    for (int k = 1; k <= N_REQ; k++) begin
      if (r[(last + k) % N_REQ]) return (last + k) % N_REQ;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'd0);
    check({tag, "_done"},  32'(done),  32'd0);
    check({tag, "_err"},   32'(err),   32'd0);
    check({tag, "_busy"},  32'(busy),  32'd0);
    check({tag, "_db"},    32'(tx_doorbell), 32'd0);
  endtask

  // One full transfer. After the doorbell edge P0, edge Pk samples
  // tx_available = (k<d) || (k>d+l). So d is the first low sample in LAUNCH,
  // and l is the number of low samples taken while in SEND.
  task automatic xfer(input logic [N_REQ-1:0] rq, input int d, input int l, input bit drop);
    int w;
    int exp_k;
    bit exp_err;
    logic [N_REQ-1:0] oh;
    w  = rr_pick(rq, last_m);
    oh = N_REQ'(1) << w;
    if (d > LAUNCH_TO) begin
      exp_k = LAUNCH_TO;  exp_err = 1'b1;
    end else if (l <= SEND_TO - 1) begin
      exp_k = d + l + 1;  exp_err = 1'b0;
    end else begin
      exp_k = d + SEND_TO; exp_err = 1'b1;
    end

    req = rq;
    tx_available = 1'b1;
    tick();
    check("grant_latch", 32'(grant), 32'(oh));
    check("sel_latch",   32'(sel),   32'(w));
    check("busy_setup",  32'(busy),  32'd1);
    check("db_setup",    32'(tx_doorbell), 32'd0);
    tick();
    check("db_pulse",    32'(tx_doorbell), 32'd1);
    check("grant_launch", 32'(grant), 32'(oh));
    if (drop) req = rq & ~oh;

    for (int k = 1; k <= exp_k; k++) begin
      tx_available = (k < d) || (k > d + l);
      tick();
      if (k < exp_k) begin
        check("done_early", 32'(done), 32'd0);
        check("db_once",    32'(tx_doorbell), 32'd0);
        check("grant_hold", 32'(grant), 32'(oh));
      end
    end
    check("done_pulse", 32'(done),  32'(oh));
    check("err_val",    32'(err),   32'(exp_err));
    check("grant_done", 32'(grant), 32'(oh));
    check("sel_done",   32'(sel),   32'(w));

    tx_available = 1'b1;
    req = rq & ~oh;
    tick();
    check_idle_outputs("after_done");
    last_m = w;
    $display("xfer req=%b winner=%0d d=%0d l=%0d err=%0d", rq, w, d, l, exp_err);
  endtask

  // Producer withdraws its request while still in SETUP (no launch possible).
  task automatic abandon(input logic [N_REQ-1:0] rq, input int hold);
    int w;
    logic [N_REQ-1:0] oh;
    w  = rr_pick(rq, last_m);
    oh = N_REQ'(1) << w;
    req = rq;
    tx_available = 1'b0;
    tick();
    check("ab_grant", 32'(grant), 32'(oh));
    for (int i = 0; i < hold; i++) begin
      tick();
      check("ab_db",    32'(tx_doorbell), 32'd0);
      check("ab_hold",  32'(grant), 32'(oh));
    end
    req = '0;
    tick();
    check_idle_outputs("ab_release");
    tx_available = 1'b1;
    $display("abandon req=%b winner=%0d", rq, w);
  endtask

  initial begin
    // Reset with requests asserted: nothing may be granted while rstn is low.
    rstn = 1'b0;
    req  = 2'b11;
    tick();
    tick();
    check_idle_outputs("reset");
    check("reset_sel", 32'(sel), 32'd0);
    req  = '0;
    rstn = 1'b1;
    tick();
    check_idle_outputs("idle_noreq");

    // Basic transfer with requester 0.
    xfer(2'b01, 3, 30, 1'b0);
    // Continuous 11: the grant must alternate.
    for (int i = 0; i < 4; i++) xfer(2'b11, 2, 5, 1'b0);
    // Launch timeout, then a normal transfer.
    xfer(2'b01, LAUNCH_TO + 5, 0, 1'b0);
    xfer(2'b10, 1, 3, 1'b0);
    // Late fall right at the launch limit still counts as started.
    xfer(2'b01, LAUNCH_TO, 4, 1'b1);
    // Abandon in SETUP.
    abandon(2'b10, 3);
    // SEND boundaries.
    xfer(2'b01, 2, SEND_TO - 1, 1'b0);
    xfer(2'b10, 2, SEND_TO, 1'b0);

    // Reset during SEND.
    req = 2'b11;
    tx_available = 1'b1;
    tick();
    tick();
    tx_available = 1'b0;
    tick();
    tick();
    tick();
    rstn = 1'b0;
    tick();
    check_idle_outputs("rst_send");
    check("rst_send_sel", 32'(sel), 32'd0);
    rstn = 1'b1;
    last_m = N_REQ - 1;
    xfer(2'b11, 2, 3, 1'b0);

    // Randomized transfers.
    for (int i = 0; i < 24; i++) begin
      logic [N_REQ-1:0] rq;
      rq = N_REQ'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0)
        abandon(rq, $urandom_range(0, 3));
      else
        xfer(rq, $urandom_range(1, LAUNCH_TO + 3), $urandom_range(0, SEND_TO + 2),
             1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
